// File: rtl/lfsr_capture_fifo.sv
// lfsr_capture_fifo
//   Captures a bounded (capture_len != 0) or continuous (capture_len == 0,
//   ended by stop) run of LFSR words into a DEPTH-entry FIFO. The bus-side
//   reader takes the words out over a valid/ready handshake. Words offered
//   while the FIFO is full and not being popped are dropped and counted.
//   The block reports capture completion with a one-cycle done pulse.
//
// Optional feature (macro LFSR_CAPTURE_STUCK_DETECT_EN):
//   If the macro is defined, stuck_err flags an offered word of zero, or an
//   offered word equal to the previous one since start. It stays set until
//   the next honoured start or rst. If the macro is undefined, stuck_err is
//   tied to 0.
//
// Ports:
//   clk, rst            clock (posedge), asynchronous active-high reset
//   start, stop         capture control pulses (start honoured in IDLE,
//                       stop honoured in CAPTURE; start wins in IDLE)
//   capture_len         words to capture, 0 = continuous; sampled on start
//   in_valid, in_data   upstream LFSR word stream (no backpressure)
//   out_valid, out_ready, out_data
//                       first-word fall-through read port
//   level               FIFO occupancy
//   busy                capture or drain in progress
//   done                one-cycle pulse when the drain completes
//   overflow_cnt        words dropped since the last start (saturating)
//   stuck_err           sticky upstream-lockup flag (see above)
//
// Handshake: a word moves from the FIFO to the consumer at every rising
// edge where out_valid && out_ready. out_valid depends only on FIFO state,
// never on out_ready. out_data reads 0 while out_valid is 0, and the
// consumer must not rely on it then.
//
// The FSM state is held in state_q (type state_t) so that checkers can
// bind to it.

module lfsr_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         capture_len,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         overflow_cnt,
    output logic                     stuck_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  offered_q;
    logic [CNT_W-1:0]  offered_next;
    logic [CNT_W-1:0]  ovf_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic full, pop, offer, push, drop, start_take;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        full         = (level_q == FULL_LVL);
        pop          = (level_q != '0) && out_ready;
        offer        = (state_q == ST_CAPTURE) && in_valid;
        // A full FIFO still takes a word when the same edge pops one.
        push         = offer && (!full || pop);
        drop         = offer && full && !pop;
        start_take   = (state_q == ST_IDLE) && start;
        offered_next = offered_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Dropped words count too, so a bounded capture always
                // spans exactly capture_len valid input cycles.
                if (stop || (offer && (len_q != '0) && (offered_next == len_q)))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (level_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            len_q     <= '0;
            offered_q <= '0;
            ovf_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (start_take) begin
                len_q     <= capture_len;
                offered_q <= '0;
            end else if (offer) begin
                offered_q <= offered_next;
            end

            if (start_take)
                ovf_q <= '0;
            else if (drop && (ovf_q != '1))
                ovf_q <= ovf_q + CNT_W'(1);

            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // The storage array has no reset. Reads are gated by level, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

`ifdef LFSR_CAPTURE_STUCK_DETECT_EN
    logic [DATA_W-1:0] prev_q;
    logic              have_prev_q;
    logic              stuck_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else if (start_take) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else if (offer) begin
            if ((in_data == '0) || (have_prev_q && (in_data == prev_q)))
                stuck_q <= 1'b1;
            prev_q      <= in_data;
            have_prev_q <= 1'b1;
        end
    end

    assign stuck_err = stuck_q;
`else
    assign stuck_err = 1'b0;
`endif

    assign out_valid    = (level_q != '0);
    assign out_data     = (level_q != '0) ? mem[rd_ptr_q] : '0;
    assign level        = level_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: doc/lfsr_capture_fifo.md
# lfsr_capture_fifo

Downstream stage of `LFSR_Pipeline`. It captures a bounded or continuous run of `lfsr_out` words into a small FIFO. It serves them to the bus-side reader (the OUTPUT_ADDR CSR path) over a valid/ready handshake. It also counts words dropped on overflow and reports capture completion.

## Interface
- `DATA_W`, 32, width of one captured LFSR word
- `DEPTH`, 8, FIFO entries; power of two, at least 2
- `CNT_W`, 16, width of `capture_len` and `overflow_cnt`

Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a capture; honoured in IDLE only
- `stop`  in  1  one-cycle pulse that ends a capture; honoured in CAPTURE only
- `capture_len`  in  CNT_W  number of words to capture; 0 = continuous until `stop`; sampled on `start`
- `in_valid`  in  1  `in_data` carries a new LFSR word this cycle
- `in_data`  in  DATA_W  LFSR word from upstream
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_data`  out  DATA_W  head of FIFO (first-word fall-through)
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on DRAIN→IDLE
- `overflow_cnt`  out  CNT_W  words dropped since last `start`; saturates at all-ones
- `stuck_err`  out  1  sticky upstream-lockup flag; see Configuration

## Operation
- States:
  - IDLE: `start` → CAPTURE. Latch `capture_len`, clear the offered-word counter, `overflow_cnt` and `stuck_err`. FIFO contents are kept.
  - CAPTURE: every `in_valid` cycle counts as one offered word. The state moves to DRAIN when the offered count reaches a nonzero latched length, or when `stop` is seen.
  - DRAIN: no input is accepted. When `level`==0 → IDLE and `done`=1 for one cycle.
- Push: `in_valid` in CAPTURE while the FIFO is not full. Full without a simultaneous pop drops the word and increments `overflow_cnt`.
- Dropped words still count toward `capture_len`, so capture length is deterministic in input cycles.
- Pop: `out_valid && out_ready`. Push and pop together leave `level` unchanged. A push while full is accepted if a pop happens in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `level`.
- `start` in CAPTURE/DRAIN and `stop` in IDLE/DRAIN are ignored. If `start` and `stop` arrive together in IDLE, `start` wins.
- `stop` coinciding with a valid word: the word is pushed, then the state moves to DRAIN.
- The last counted word and the DRAIN transition occur on the same edge.

## Timing
- Reset values: all outputs are 0, state is IDLE, FIFO is empty, pointers are 0.
- `rst` mid-capture discards FIFO contents immediately; no `done` pulse is issued.
- `start` at edge N: state is CAPTURE after N. The first word that can be accepted is sampled at edge N+1. `in_valid` in the `start` cycle is ignored.
- Push at edge N: `out_valid`=1 and `out_data`=word after N (1-cycle latency).
- `level` and `overflow_cnt` reflect the edge's push/pop/drop immediately after it.
- `done` asserts the cycle after the edge at which `level` is seen at 0 in DRAIN.
- The consumer must not assume `out_data` is stable when `out_valid`=0.

## Configuration
- `LFSR_CAPTURE_STUCK_DETECT_EN` defined:
  - In CAPTURE, an offered word that equals 0 sets `stuck_err`.
  - An offered word equal to the previous offered word since `start` also sets `stuck_err`.
  - `stuck_err` stays sticky until the next honoured `start` or `rst`.
  - Detection adds one DATA_W previous-word register.
- Macro undefined: `stuck_err` is tied to 0 and no compare logic is present.

## Test plan
- Bounded capture, no backpressure: `capture_len`=4, words 1234FADC, 2469F5B9, 48D3EB72, 91A7D6E5, `out_ready`=1 → the same four words appear in order, `overflow_cnt`=0, `done` pulses once, `busy`=0 after.
- Overflow, DEPTH=8: `capture_len`=12, `out_ready`=0 → `level`=8, `overflow_cnt`=4. Then `out_ready`=1 → the first 8 words drain in order, followed by `done`.
- Continuous and stop: `capture_len`=0, 20 valid words with `out_ready`=1, `stop` together with word 20 → 20 words out, then `done`.
- Full with simultaneous push/pop: FIFO full, `in_valid`=1 and `out_ready`=1 for 5 cycles → `level` holds 8, no drops, order preserved.
- Reset mid-capture: `rst` pulse after 3 words → `out_valid`=0, `level`=0, `busy`=0, no `done`. A new `start` then works normally.
- Stuck detect (macro on): words 0000_0001, 0000_0001 → `stuck_err`=1 after the 2nd push. A later `start` clears it. With the macro off → `stuck_err` stays 0.
